// File: rtl/pdm_decimator.sv
// PDM-to-level decimator: counts the ones in each window of 2^WINDOW_LOG2
// qualified samples and reports the count with a one-cycle valid/changed strobe.
module pdm_decimator #(
  parameter int WINDOW_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pdm_in,
  input  logic                   en,
  input  logic                   clear,
  output logic [WINDOW_LOG2:0]   level,
  output logic                   valid,
  output logic                   changed
);

  localparam logic [WINDOW_LOG2-1:0] LAST = '1;

  logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
  logic [WINDOW_LOG2:0]   acc_q, acc_d;
  logic [WINDOW_LOG2:0]   level_q, level_d;
  logic [WINDOW_LOG2:0]   sum;
  logic                   valid_q, valid_d;
  logic                   changed_q, changed_d;

  // acc never exceeds N-1 before the add, so the extra bit absorbs the all-ones window.
  assign sum = acc_q + {{WINDOW_LOG2{1'b0}}, pdm_in};

  always_comb begin
    wcnt_d    = wcnt_q;
    acc_d     = acc_q;
    level_d   = level_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    if (clear) begin
      wcnt_d = '0;
      acc_d  = '0;
    end else if (en) begin
      if (wcnt_q == LAST) begin
        level_d   = sum;
        valid_d   = 1'b1;
        changed_d = (sum != level_q);
        acc_d     = '0;
        wcnt_d    = '0;
      end else begin
        acc_d  = sum;
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q    <= '0;
      acc_q     <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      acc_q     <= acc_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  assign level   = level_q;
  assign valid   = valid_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: window-pattern table, directed corner sequences and
// random traffic, all compared against a sample-queue reference model.
module tb_pdm_decimator;
  localparam int WL = 5;
  localparam int N  = 1 << WL;

  logic          clk = 1'b0;
  logic          reset, pdm_in, en, clear;
  logic [WL:0]   level;
  logic          valid, changed;

  pdm_decimator #(.WINDOW_LOG2(WL)) dut (
    .clk(clk), .reset(reset), .pdm_in(pdm_in), .en(en), .clear(clear),
    .level(level), .valid(valid), .changed(changed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the samples of the open window, and the last reported level.
  int win[$];
  int m_level;
  bit m_valid, m_changed;

  int enc_acc;

  typedef struct {
    logic [31:0] bits;
    int          exp_level;
    bit          exp_changed;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic m_reset();
    win.delete();
    m_level   = 0;
    m_valid   = 1'b0;
    m_changed = 1'b0;
  endtask

  task automatic step(input bit p, input bit e, input bit c, input string tag);
    int s;
    pdm_in = p; en = e; clear = c;
    @(posedge clk); #1;
    m_valid = 1'b0; m_changed = 1'b0;
    if (c) win.delete();
    else if (e) begin
      win.push_back(p);
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        m_changed = (s != m_level);
        m_level   = s;
        m_valid   = 1'b1;
        win.delete();
      end
    end
    chk({tag, ".valid"},   valid,   m_valid);
    chk({tag, ".changed"}, changed, m_changed);
    chk({tag, ".level"},   level,   m_level);
  endtask

  // First-order sigma-delta source: ones density L/N.
  task automatic enc(input int l, output bit b);
    enc_acc += l;
    if (enc_acc >= N) begin enc_acc -= N; b = 1'b1; end
    else b = 1'b0;
  endtask

  initial begin
    int vcount, d;
    bit b;
    int loads[4];
    tbl[0] = '{32'h0000_0000,  0, 1'b1};
    tbl[1] = '{32'hFFFF_FFFF, 32, 1'b1};
    tbl[2] = '{32'hFFFF_FFFF, 32, 1'b0};
    tbl[3] = '{32'h5555_5555, 16, 1'b1};
    tbl[4] = '{32'hAAAA_AAAA, 16, 1'b0};
    tbl[5] = '{32'h0000_0001,  1, 1'b1};
    tbl[6] = '{32'h8000_0000,  1, 1'b0};
    tbl[7] = '{32'h0F0F_00FF, 16, 1'b1};
    loads = '{8, 26, 15, 4};

    reset = 1'b1; pdm_in = 1'b0; en = 1'b0; clear = 1'b0;
    m_reset();
    #12;
    chk("rst.level", level, 0);
    chk("rst.valid", valid, 0);
    chk("rst.changed", changed, 0);
    @(negedge clk); reset = 1'b0;

    // Constant ones: first valid on the 32nd sample, then an unchanged repeat.
    for (int i = 0; i < N; i++) step(1, 1, 0, "ones1");
    chk("ones1.v", valid, 1); chk("ones1.l", level, 32); chk("ones1.c", changed, 1);
    for (int i = 0; i < N; i++) step(1, 1, 0, "ones2");
    chk("ones2.v", valid, 1); chk("ones2.l", level, 32); chk("ones2.c", changed, 0);

    // Alternating 1,0: level 16, changed only on the first window.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < N; i++) step(((i % 2) == 0), 1, 0, "alt");
      chk("alt.l", level, 16); chk("alt.c", changed, (w == 0));
    end

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) step(tbl[t].bits[i], 1, 0, "tbl");
      chk($sformatf("tbl%0d.v", t), valid, 1);
      chk($sformatf("tbl%0d.l", t), level, tbl[t].exp_level);
      chk($sformatf("tbl%0d.c", t), changed, tbl[t].exp_changed);
    end

    // en on every other cycle: one window spans 64 clocks.
    step(0, 0, 1, "en_clr");
    vcount = 0;
    for (int i = 0; i < 2 * N; i++) begin
      step(1, (i % 2) == 1, 0, "entog");
      if (i < 2 * N - 1 && valid) vcount++;
    end
    chk("entog.early_valids", vcount, 0);
    chk("entog.v", valid, 1); chk("entog.l", level, 32); chk("entog.c", changed, 1);

    // Clear discards the partial window and its own sample.
    step(0, 0, 1, "clr0");
    for (int i = 0; i < 10; i++) step(1, 1, 0, "pre_clr");
    step(1, 1, 1, "clr");
    chk("clr.level_held", level, 32);
    for (int i = 0; i < N; i++) step(0, 1, 0, "post_clr");
    chk("clr.v", valid, 1); chk("clr.l", level, 0); chk("clr.c", changed, 1);

    // Asynchronous reset mid-window, between edges.
    for (int i = 0; i < N; i++) step(1, 1, 0, "pre_rst_full");
    for (int i = 0; i < 20; i++) step(1, 1, 0, "pre_rst");
    @(negedge clk); reset = 1'b1; #1;
    chk("arst.level", level, 0); chk("arst.valid", valid, 0); chk("arst.changed", changed, 0);
    m_reset();
    #2 reset = 1'b0;
    for (int i = 0; i < N; i++) step(i < 7, 1, 0, "post_rst");
    chk("arst.v", valid, 1); chk("arst.l", level, 7); chk("arst.c", changed, 1);

    // Sigma-delta source: settled windows land within one count of the load.
    step(0, 0, 1, "enc_clr");
    enc_acc = 0;
    foreach (loads[k]) begin
      for (int w = 0; w < 3; w++) begin
        for (int i = 0; i < N; i++) begin
          enc(loads[k], b);
          step(b, 1, 0, "enc");
        end
        if (w > 0) begin
          d = int'(level) - loads[k];
          chk($sformatf("enc%0d.within1", loads[k]), (d >= -1 && d <= 1), 1);
        end
      end
    end

    // Random traffic with occasional clears and idle cycles.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pdm_decimator.md
PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 5, meaning log2 of the decimation window length N (N = 2^WINDOW_LOG2, legal 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pdm_in  input  1  PDM bitstream from the upstream PDM encoder, one sample per clk when en=1.
REQ-005 SHALL have port en  input  1  sample qualifier; 0 = sample ignored, all state held.
REQ-006 SHALL have port clear  input  1  synchronous window restart.
REQ-007 SHALL have port level  output  WINDOW_LOG2+1  count of ones in the last completed window (0..N).
REQ-008 SHALL have port valid  output  1  one-cycle strobe: level updated this cycle.
REQ-009 SHALL have port changed  output  1  one-cycle strobe, coincident with valid, when the new level differs from the previous level.

Function
REQ-010 SHALL keep a window counter wcnt (WINDOW_LOG2 bits) and an accumulator acc (WINDOW_LOG2+1 bits).
REQ-011 SHALL, on an edge with en=1, clear=0, wcnt<N-1: acc <= acc + pdm_in; wcnt <= wcnt+1; valid <= 0; changed <= 0.
REQ-012 SHALL, on an edge with en=1, clear=0, wcnt=N-1: level <= acc + pdm_in; valid <= 1; changed <= (acc+pdm_in != level); acc <= 0; wcnt <= 0.
REQ-013 SHALL give latency 1 clock: valid is high in the cycle after the edge that sampled the N-th bit of a window.
REQ-014 SHALL count exactly N sampled bits per window; cycles with en=0 are not counted and do not advance wcnt.
REQ-015 SHALL, on an edge with en=0 and clear=0, hold wcnt, acc and level, and drive valid=0 and changed=0.
REQ-016 SHALL give clear priority over en: on an edge with clear=1, wcnt <= 0, acc <= 0, valid <= 0, changed <= 0, level held; the pdm_in sample on that edge is discarded.
REQ-017 SHALL never overflow: acc+pdm_in is at most N and fits WINDOW_LOG2+1 bits; level=N is legal (all-ones window).
REQ-018 SHALL hold valid high for exactly one cycle per completed window, including back-to-back windows with en held high (valid every N cycles).
REQ-019 SHALL compute changed against the level register value before the update; the first window after reset compares against 0.
REQ-020 SHALL drive level, valid and changed directly from flops (no combinational path from inputs to outputs).

Reset
REQ-021 SHALL, while reset=1, asynchronously force wcnt=0, acc=0, level=0, valid=0, changed=0.
REQ-022 SHALL, after reset deasserts mid-window, start a fresh window; no partial window is ever reported.
REQ-023 SHALL sample pdm_in first on the first rising edge after reset deassertion that has en=1.

Verification
REQ-024 SHALL cover: reset, en=1, pdm_in=1 constant, N=32 -> valid at cycle 32 after first sample, level=32, changed=1; next window level=32, changed=0.
REQ-025 SHALL cover: pdm_in alternating 1,0 with en=1 -> every window level=16; changed=1 only on the first window.
REQ-026 SHALL cover: en toggled 1,0 each cycle with pdm_in=1 -> valid after 64 clocks, level=32; no valid in between.
REQ-027 SHALL cover: 10 ones sampled, then clear=1 for one edge, then 32 zeros -> the next valid reports level=0, not 10.
REQ-028 SHALL cover: reset pulse asserted asynchronously between clock edges mid-window after 20 ones -> level=0 and valid=0 immediately; the next window reports only post-reset samples.
REQ-029 SHALL cover: upstream PDM encoder loaded with levels 8, 26, 15, 4 and run into this block with en=1 -> after one settling window, each reported level is within +/-1 of the loaded level.
